// File: rtl/cnn_sched_pkg.sv
// Shared types and width helpers for the CNN weight scheduler.
package cnn_sched_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_e;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/weight_sched_counter_if.sv
// Control and status bundle between a frame sequencer and the weight scheduler.
interface weight_sched_counter_if #(
  parameter int unsigned NUM_W     = 10,
  parameter int unsigned PIX_PER_W = 28,
  parameter int unsigned NUM_CH    = 1
);
  import cnn_sched_pkg::*;

  localparam int unsigned WW = cnt_w(NUM_W);
  localparam int unsigned PW = cnt_w(PIX_PER_W);
  localparam int unsigned CW = cnt_w(NUM_CH);

  logic          start;
  logic          abort;
  logic          en;
  logic [WW-1:0] cfg_num_w_m1;
  logic [PW-1:0] cfg_pix_m1;
  logic [PW-1:0] pix_cnt;
  logic [WW-1:0] weight_num;
  logic [CW-1:0] ch_num;
  logic          w_last;
  logic          frame_done;
  logic          busy;

  modport master (
    output start, abort, en, cfg_num_w_m1, cfg_pix_m1,
    input  pix_cnt, weight_num, ch_num, w_last, frame_done, busy
  );

  modport slave (
    input  start, abort, en, cfg_num_w_m1, cfg_pix_m1,
    output pix_cnt, weight_num, ch_num, w_last, frame_done, busy
  );

endinterface

// File: rtl/sched_wrap_cnt.sv
// Wrapping counter stage; wrap marks an increment taken at the limit so stages chain.
module sched_wrap_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  input  logic [W-1:0] lim,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign wrap = inc && (cnt_q == lim);
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = wrap ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/weight_sched_counter.sv
// Sweeps pixel / weight-set / channel indices for one frame of pooled-pixel reads.
module weight_sched_counter
  import cnn_sched_pkg::*;
#(
  parameter int unsigned NUM_W         = 10,
  parameter int unsigned PIX_PER_W     = 28,
  parameter int unsigned NUM_CH        = 1,
  parameter int unsigned CLEAR_ON_IDLE = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  weight_sched_counter_if.slave  sif
);

  localparam int unsigned WW = cnt_w(NUM_W);
  localparam int unsigned PW = cnt_w(PIX_PER_W);
  localparam int unsigned CW = cnt_w(NUM_CH);

  localparam logic [PW-1:0] PIX_MAX = PW'(PIX_PER_W - 1);
  localparam logic [WW-1:0] W_MAX   = WW'(NUM_W - 1);
  localparam logic [CW-1:0] CH_MAX  = CW'(NUM_CH - 1);
  localparam logic          CLR_EN  = (CLEAR_ON_IDLE != 0);

  sched_state_e  state_q, state_d;
  logic [PW-1:0] pix_lim_q, pix_lim_d;
  logic [WW-1:0] w_lim_q, w_lim_d;
  logic          frame_done_q, frame_done_d;
  logic          busy_q, busy_d;

  logic          adv_c;
  logic          clr_c;
  logic          pix_wrap_c;
  logic          w_wrap_c;
  logic          ch_wrap_c;
  logic [PW-1:0] pix_cnt;
  logic [WW-1:0] weight_num;
  logic [CW-1:0] ch_num;

  // Advance and clear are mutually exclusive; abort always forces a clear.
  assign adv_c = (state_q == ST_RUN) && sif.en && !sif.abort;
  assign clr_c = sif.abort || (state_q == ST_IDLE)
              || ((state_q == ST_RUN) && !sif.en && CLR_EN);

  sched_wrap_cnt #(.W(PW)) u_pix (
    .clk   (clk),
    .reset (reset),
    .inc   (adv_c),
    .clr   (clr_c),
    .lim   (pix_lim_q),
    .cnt   (pix_cnt),
    .wrap  (pix_wrap_c)
  );

  sched_wrap_cnt #(.W(WW)) u_wgt (
    .clk   (clk),
    .reset (reset),
    .inc   (pix_wrap_c),
    .clr   (clr_c),
    .lim   (w_lim_q),
    .cnt   (weight_num),
    .wrap  (w_wrap_c)
  );

  sched_wrap_cnt #(.W(CW)) u_ch (
    .clk   (clk),
    .reset (reset),
    .inc   (w_wrap_c),
    .clr   (clr_c),
    .lim   (CH_MAX),
    .cnt   (ch_num),
    .wrap  (ch_wrap_c)
  );

  // Frame control: configuration is captured only when a frame is accepted.
  always_comb begin
    state_d      = state_q;
    pix_lim_d    = pix_lim_q;
    w_lim_d      = w_lim_q;
    frame_done_d = 1'b0;
    if (sif.abort) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_IDLE) begin
      if (sif.start) begin
        state_d   = ST_RUN;
        pix_lim_d = (sif.cfg_pix_m1 > PIX_MAX) ? PIX_MAX : sif.cfg_pix_m1;
        w_lim_d   = (sif.cfg_num_w_m1 > W_MAX) ? W_MAX : sif.cfg_num_w_m1;
      end
    end else if (ch_wrap_c) begin
      state_d      = ST_IDLE;
      frame_done_d = 1'b1;
    end
    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      pix_lim_q    <= PIX_MAX;
      w_lim_q      <= W_MAX;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_lim_q    <= pix_lim_d;
      w_lim_q      <= w_lim_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign sif.pix_cnt    = pix_cnt;
  assign sif.weight_num = weight_num;
  assign sif.ch_num     = ch_num;
  assign sif.w_last     = (pix_cnt == pix_lim_q);
  assign sif.frame_done = frame_done_q;
  assign sif.busy       = busy_q;

endmodule

// File: tb/tb_weight_sched_counter.sv
// Directed bench for weight_sched_counter across clear, pause and multi-channel builds.
module tb_weight_sched_counter;

  logic clk;
  logic reset;

  int n_vec = 0;
  int n_err = 0;
  int fd_cnt_a = 0;
  int fd_cnt_c = 0;
  int snap;

  weight_sched_counter_if #(.NUM_W(10), .PIX_PER_W(28), .NUM_CH(1)) ifa ();
  weight_sched_counter_if #(.NUM_W(10), .PIX_PER_W(28), .NUM_CH(1)) ifb ();
  weight_sched_counter_if #(.NUM_W(10), .PIX_PER_W(28), .NUM_CH(3)) ifc ();

  weight_sched_counter #(.NUM_W(10), .PIX_PER_W(28), .NUM_CH(1), .CLEAR_ON_IDLE(1)) dut_a (
    .clk(clk), .reset(reset), .sif(ifa)
  );
  weight_sched_counter #(.NUM_W(10), .PIX_PER_W(28), .NUM_CH(1), .CLEAR_ON_IDLE(0)) dut_b (
    .clk(clk), .reset(reset), .sif(ifb)
  );
  weight_sched_counter #(.NUM_W(10), .PIX_PER_W(28), .NUM_CH(3), .CLEAR_ON_IDLE(1)) dut_c (
    .clk(clk), .reset(reset), .sif(ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters used to prove no frame_done appears after abort or reset.
  always @(posedge clk) begin
    if (ifa.frame_done === 1'b1) fd_cnt_a++;
    if (ifc.frame_done === 1'b1) fd_cnt_c++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int pix, input int w, input int fd, input int bsy);
    check({tag, "_pix"},  32'(ifa.pix_cnt),    pix);
    check({tag, "_w"},    32'(ifa.weight_num), w);
    check({tag, "_fd"},   32'(ifa.frame_done), fd);
    check({tag, "_busy"}, 32'(ifa.busy),       bsy);
  endtask

  task automatic chk_c(input string tag, input int ch, input int w, input int pix, input int fd, input int bsy);
    check({tag, "_ch"},   32'(ifc.ch_num),     ch);
    check({tag, "_w"},    32'(ifc.weight_num), w);
    check({tag, "_pix"},  32'(ifc.pix_cnt),    pix);
    check({tag, "_fd"},   32'(ifc.frame_done), fd);
    check({tag, "_busy"}, 32'(ifc.busy),       bsy);
  endtask

  initial begin
    reset = 1'b0;
    ifa.start = 1'b0; ifa.abort = 1'b0; ifa.en = 1'b0; ifa.cfg_num_w_m1 = '0; ifa.cfg_pix_m1 = '0;
    ifb.start = 1'b0; ifb.abort = 1'b0; ifb.en = 1'b0; ifb.cfg_num_w_m1 = '0; ifb.cfg_pix_m1 = '0;
    ifc.start = 1'b0; ifc.abort = 1'b0; ifc.en = 1'b0; ifc.cfg_num_w_m1 = '0; ifc.cfg_pix_m1 = '0;
    tick(2);
    chk_a("rst_a", 0, 0, 0, 0);
    check("rst_a_wlast", 32'(ifa.w_last), 0);
    chk_c("rst_c", 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick(1);

    // Full default frame: 10 weight sets x 28 pixels
    ifa.cfg_num_w_m1 = 4'd9; ifa.cfg_pix_m1 = 5'd27; ifa.start = 1'b1; ifa.en = 1'b1;
    tick(1);
    ifa.start = 1'b0;
    chk_a("t1_start", 0, 0, 0, 1);
    tick(28);
    chk_a("t1_adv28", 0, 1, 0, 1);
    tick(27);
    chk_a("t1_adv55", 27, 1, 0, 1);
    check("t1_adv55_wlast", 32'(ifa.w_last), 1);
    tick(1);
    check("t1_adv56_w", 32'(ifa.weight_num), 2);
    check("t1_adv56_wlast", 32'(ifa.w_last), 0);
    tick(223);
    chk_a("t1_adv279", 27, 9, 0, 1);
    tick(1);
    chk_a("t1_final", 0, 0, 1, 0);
    tick(1);
    chk_a("t1_idle_en", 0, 0, 0, 0);

    // Clear on en low, then start while running must not reload config
    ifa.start = 1'b1;
    tick(1);
    ifa.start = 1'b0;
    tick(99);
    chk_a("t2_p15w3", 15, 3, 0, 1);
    ifa.en = 1'b0;
    tick(1);
    chk_a("t2_clear", 0, 0, 0, 1);
    ifa.en = 1'b1;
    tick(1);
    check("t2_resume_pix", 32'(ifa.pix_cnt), 1);
    ifa.cfg_pix_m1 = 5'd3; ifa.cfg_num_w_m1 = 4'd0; ifa.start = 1'b1;
    tick(1);
    ifa.start = 1'b0;
    chk_a("t2_restart_ign", 2, 0, 0, 1);
    tick(25);
    check("t2_p27_pix", 32'(ifa.pix_cnt), 27);
    check("t2_p27_wlast", 32'(ifa.w_last), 1);
    tick(1);
    chk_a("t2_wrap", 0, 1, 0, 1);
    ifa.abort = 1'b1;
    tick(1);
    ifa.abort = 1'b0;
    chk_a("t2_abort", 0, 0, 0, 0);

    // Out-of-range pixel limit clamps to 27; single weight set
    ifa.cfg_pix_m1 = 5'd31; ifa.cfg_num_w_m1 = 4'd0; ifa.start = 1'b1;
    tick(1);
    ifa.start = 1'b0;
    check("t3_wlast0", 32'(ifa.w_last), 0);
    tick(27);
    chk_a("t3_p27", 27, 0, 0, 1);
    check("t3_p27_wlast", 32'(ifa.w_last), 1);
    tick(1);
    chk_a("t3_done", 0, 0, 1, 0);

    // Minimal 1x1 frame, then abort coinciding with the final advance
    ifa.cfg_pix_m1 = 5'd0; ifa.cfg_num_w_m1 = 4'd0; ifa.start = 1'b1;
    tick(1);
    ifa.start = 1'b0;
    check("t3b_wlast", 32'(ifa.w_last), 1);
    check("t3b_busy", 32'(ifa.busy), 1);
    tick(1);
    chk_a("t3b_done", 0, 0, 1, 0);
    ifa.start = 1'b1;
    tick(1);
    ifa.start = 1'b0;
    ifa.abort = 1'b1;
    tick(1);
    ifa.abort = 1'b0;
    chk_a("t3c_abort_final", 0, 0, 0, 0);
    tick(1);
    check("t3c_no_fd", 32'(ifa.frame_done), 0);

    // Asynchronous reset mid-frame
    snap = fd_cnt_a;
    ifa.cfg_pix_m1 = 5'd27; ifa.cfg_num_w_m1 = 4'd9; ifa.start = 1'b1;
    tick(1);
    ifa.start = 1'b0;
    tick(122);
    chk_a("t4_p10w4", 10, 4, 0, 1);
    reset = 1'b0;
    #1;
    chk_a("t4_async", 0, 0, 0, 0);
    tick(2);
    reset = 1'b1;
    tick(3);
    check("t4_busy_after", 32'(ifa.busy), 0);
    check("t4_no_fd", 32'(fd_cnt_a - snap), 0);
    ifa.en = 1'b0;

    // Pause build: en low holds the counters
    ifb.cfg_num_w_m1 = 4'd9; ifb.cfg_pix_m1 = 5'd27; ifb.start = 1'b1; ifb.en = 1'b1;
    tick(1);
    ifb.start = 1'b0;
    tick(15);
    check("t5_p15", 32'(ifb.pix_cnt), 15);
    ifb.en = 1'b0;
    tick(5);
    check("t5_hold_pix", 32'(ifb.pix_cnt), 15);
    check("t5_hold_busy", 32'(ifb.busy), 1);
    ifb.en = 1'b1;
    tick(1);
    check("t5_resume", 32'(ifb.pix_cnt), 16);
    ifb.abort = 1'b1;
    tick(1);
    ifb.abort = 1'b0; ifb.en = 1'b0;
    check("t5_abort_busy", 32'(ifb.busy), 0);

    // Three-channel frame
    ifc.cfg_num_w_m1 = 4'd9; ifc.cfg_pix_m1 = 5'd27; ifc.start = 1'b1; ifc.en = 1'b1;
    tick(1);
    ifc.start = 1'b0;
    tick(280);
    chk_c("t6_adv280", 1, 0, 0, 0, 1);
    tick(279);
    chk_c("t6_adv559", 1, 9, 27, 0, 1);
    tick(1);
    chk_c("t6_adv560", 2, 0, 0, 0, 1);
    tick(279);
    chk_c("t6_adv839", 2, 9, 27, 0, 1);
    tick(1);
    chk_c("t6_done", 0, 0, 0, 1, 0);
    tick(1);
    check("t6_fd_pulse", 32'(ifc.frame_done), 0);

    // Repeat run with abort and start together at advance 500
    snap = fd_cnt_c;
    ifc.start = 1'b1;
    tick(1);
    ifc.start = 1'b0;
    tick(500);
    chk_c("t7_adv500", 1, 7, 24, 0, 1);
    ifc.abort = 1'b1; ifc.start = 1'b1;
    tick(1);
    ifc.abort = 1'b0; ifc.start = 1'b0;
    chk_c("t7_abort_start", 0, 0, 0, 0, 0);
    tick(300);
    check("t7_still_idle", 32'(ifc.busy), 0);
    check("t7_no_fd", 32'(fd_cnt_c - snap), 0);
    ifc.en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/weight_sched_counter.md
WEIGHT_SCHED_COUNTER -- requirements
Module: weight_sched_counter

Interface
REQ-001 Parameter NUM_W, default 10: number of weight sets per channel, >= 1.
REQ-002 Parameter PIX_PER_W, default 28: pooled pixels consumed per weight set, >= 1.
REQ-003 Parameter NUM_CH, default 1: number of input channels swept per frame, >= 1.
REQ-004 Parameter CLEAR_ON_IDLE, default 1: 1 = en low clears counters; 0 = en low holds counters (pause).
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  one-cycle pulse; begins a frame and latches the configuration.
REQ-008 abort  input  1  synchronous clear to IDLE; highest priority after reset.
REQ-009 en  input  1  pool read enable; each cycle with en high in RUN is one pixel advance.
REQ-010 cfg_num_w_m1  input  clog2(NUM_W)  weight sets minus one, sampled on start.
REQ-011 cfg_pix_m1  input  clog2(PIX_PER_W)  pixels per weight minus one, sampled on start.
REQ-012 pix_cnt  output  clog2(PIX_PER_W)  current pixel index within the weight set.
REQ-013 weight_num  output  clog2(NUM_W)  current weight-set select.
REQ-014 ch_num  output  max(1,clog2(NUM_CH))  current channel index.
REQ-015 w_last  output  1  high while pix_cnt equals the latched pixel limit.
REQ-016 frame_done  output  1  one-cycle pulse on frame completion.
REQ-017 busy  output  1  high in state RUN.

Function
REQ-018 States: IDLE, RUN. start in IDLE -> RUN; the final advance in RUN -> IDLE; abort in any state -> IDLE.
REQ-019 start received in RUN shall be ignored; the latched configuration shall not change.
REQ-020 On start, latch pix_lim = min(cfg_pix_m1, PIX_PER_W-1) and w_lim = min(cfg_num_w_m1, NUM_W-1); clamp out-of-range values and do not flag them.
REQ-021 Counter order: pix_cnt innermost, weight_num middle, ch_num outermost.
REQ-022 On an advance with pix_cnt < pix_lim: pix_cnt +1.
REQ-023 On an advance with pix_cnt == pix_lim: pix_cnt -> 0 and weight_num +1; if weight_num == w_lim, weight_num -> 0 and ch_num +1.
REQ-024 Final advance: pix_cnt == pix_lim, weight_num == w_lim and ch_num == NUM_CH-1. All counters -> 0, state -> IDLE, frame_done = 1 in the following cycle only.
REQ-025 With CLEAR_ON_IDLE=1, en low in RUN shall zero all counters at the next edge; state stays RUN.
REQ-026 With CLEAR_ON_IDLE=0, en low in RUN shall hold all counters.
REQ-027 In IDLE, counters shall hold 0 regardless of en.
REQ-028 abort and start in the same cycle: abort wins; result is IDLE with counters 0.
REQ-029 abort never produces frame_done, including when it coincides with the final advance.
REQ-030 All outputs shall be registered; w_last shall be decoded from registered state only, with zero added latency.

Reset
REQ-031 On reset low: state IDLE, pix_cnt = 0, weight_num = 0, ch_num = 0, frame_done = 0, busy = 0, pix_lim = PIX_PER_W-1, w_lim = NUM_W-1.
REQ-032 Reset asserted mid-frame shall abandon the frame immediately; no frame_done follows.

Structure
REQ-033 Package cnn_sched_pkg shall hold the state enum and the width helper functions (clog2-based, minimum 1).
REQ-034 Sub-module sched_wrap_cnt (inputs inc, clr, lim; outputs cnt, wrap) shall be instantiated three times, chained through wrap.
REQ-035 The target implementation size is 120-250 lines of RTL including the sub-module.

Verification
REQ-036 Reset mid-run at pix 10, weight 4 -> all outputs 0 and busy 0 in the same cycle; no frame_done.
REQ-037 Defaults, start with cfg 9/27, en held high -> weight_num steps every 28 cycles; frame_done at cycle 281 after the first advance; busy then 0.
REQ-038 CLEAR_ON_IDLE=1, en low at pix 15, weight 3 -> next cycle pix 0, weight 0, busy 1.
REQ-039 CLEAR_ON_IDLE=0, en low 5 cycles at pix 15 -> holds at 15; first en-high edge gives 16.
REQ-040 cfg_pix_m1=31 (clamped to 27), cfg_num_w_m1=0 -> w_last at pix 27; frame_done after 28 advances.
REQ-041 NUM_CH=3, defaults -> ch_num steps every 280 advances; frame_done after 840. A repeat run with abort plus start in the same cycle at advance 500 -> IDLE, no frame_done.
